// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register (optional HLT predecode: FETCH_HALT_DETECT_EN)
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] redirect_pc,
  input  logic        halt_req,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] instruction,
  output logic [15:0] pc_plus2,
  output logic        if_valid,
  output logic        halted
);

  typedef enum logic {FETCH, HALTED} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] instr_n, pc_plus2_n;
  logic        if_valid_n;
  logic [15:0] pc_inc;
  logic        is_hlt;

  // PC+2 wraps naturally at 16 bits
  assign pc_inc    = pc + 16'd2;
  assign imem_addr = pc;
  // no request while reset is held, even though the state already reads FETCH
  assign imem_req  = (state == FETCH) && !rst;
  assign halted    = (state == HALTED);

`ifdef FETCH_HALT_DETECT_EN
  assign is_hlt = (imem_data[15:12] == 4'hF);
`else
  assign is_hlt = 1'b0;
`endif

  // next-state selection: flush beats stall, stall beats halt and normal fetch
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instruction;
    pc_plus2_n = pc_plus2;
    if_valid_n = if_valid;
    if (flush) begin
      state_n    = FETCH;
      pc_n       = {redirect_pc[15:1], 1'b0};
      instr_n    = NOP_INSTR;
      if_valid_n = 1'b0;
    end else if (stall) begin
      // everything holds; the same address is refetched afterwards
    end else if (state == HALTED) begin
      instr_n    = NOP_INSTR;
      if_valid_n = 1'b0;
    end else if (halt_req) begin
      state_n    = HALTED;
      instr_n    = NOP_INSTR;
      if_valid_n = 1'b0;
    end else if (imem_valid) begin
      instr_n    = imem_data;
      pc_plus2_n = pc_inc;
      if_valid_n = 1'b1;
      if (is_hlt) begin
        // HLT goes to decode but fetch parks on its address
        state_n = HALTED;
      end else begin
        pc_n = pc_inc;
      end
    end else begin
      instr_n    = NOP_INSTR;
      if_valid_n = 1'b0;
    end
  end

  // state, PC and IF/ID registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      pc_plus2    <= 16'h0000;
      if_valid    <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instruction <= instr_n;
      pc_plus2    <= pc_plus2_n;
      if_valid    <= if_valid_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with randomized stimulus and reference model
module tb_fetch_stage;

  localparam logic [15:0] RPC = 16'h0000;
  localparam logic [15:0] NOP = 16'h7E00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, halt_req = 1'b0, imem_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000, imem_data = 16'h0000;
  logic [15:0] imem_addr, instruction, pc_plus2;
  logic        imem_req, if_valid, halted;

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_data(imem_data), .imem_valid(imem_valid), .instruction(instruction),
    .pc_plus2(pc_plus2), .if_valid(if_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        req;
    logic [15:0] instr;
    logic [15:0] pp2;
    logic        valid;
    logic        hlt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model state
  logic [15:0] m_pc, m_instr, m_pp2;
  logic        m_valid, m_halted;

  function automatic logic [15:0] mem(input logic [15:0] a);
    logic [15:0] h;
    if (a == 16'h0020) return 16'hF000;
    h = (a * 16'h2F1B) ^ 16'h1357;
    return {1'b0, h[14:0]};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_instr = NOP; m_pp2 = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_addr", imem_addr, RPC);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_instr", instruction, NOP);
    chk("rst_pp2", pc_plus2, 16'h0000);
    chk("rst_valid", {15'd0, if_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
  endtask

  // one clock of stimulus: drive inputs, advance the model, queue the post-edge expectation
  task automatic cycle(input bit s, input bit f, input logic [15:0] rp, input bit h, input bit iv);
    logic [15:0] d;
    exp_t e;
    d = iv ? mem(m_pc) : 16'($urandom);
    stall = s; flush = f; redirect_pc = rp; halt_req = h; imem_valid = iv; imem_data = d;
    if (f) begin
      m_pc = rp & 16'hFFFE; m_valid = 1'b0; m_instr = NOP; m_halted = 1'b0;
    end else if (s) begin
    end else if (m_halted || h) begin
      m_halted = 1'b1; m_valid = 1'b0; m_instr = NOP;
    end else if (iv) begin
      m_instr = d; m_pp2 = m_pc + 16'd2; m_valid = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
      if (d[15:12] == 4'hF) m_halted = 1'b1;
      else m_pc = m_pc + 16'd2;
`else
      m_pc = m_pc + 16'd2;
`endif
    end else begin
      m_valid = 1'b0; m_instr = NOP;
    end
    e.addr = m_pc; e.req = !m_halted; e.instr = m_instr;
    e.pp2 = m_pp2; e.valid = m_valid; e.hlt = m_halted;
    q.push_back(e);
    @(negedge clk);
  endtask

  // monitor: after every rising edge compare the DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0 && !rst) begin
        e = q.pop_front();
        chk("imem_addr", imem_addr, e.addr);
        chk("imem_req", {15'd0, imem_req}, {15'd0, e.req});
        chk("instruction", instruction, e.instr);
        chk("pc_plus2", pc_plus2, e.pp2);
        chk("if_valid", {15'd0, if_valid}, {15'd0, e.valid});
        chk("halted", {15'd0, halted}, {15'd0, e.hlt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    #1;
    chk("first_req", {15'd0, imem_req}, 16'd1);
    chk("first_addr", imem_addr, RPC);

    // straight-line fetch up to PC 6, two wait states, then the word at 6
    repeat (3) cycle(0, 0, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 1);

    // stall for three cycles, halt_req under stall, then stall+flush to 0x40
    repeat (3) cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 1, 16'h0040, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 1);

    // wrap through 0xFFFE
    cycle(0, 1, 16'hFFFE, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 1);

    // halt_req pulse, stay halted, resume by flush to 0x10
    cycle(0, 0, 0, 1, 1);
    repeat (2) cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 16'h0010, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 1);

    // HLT word at 0x20, odd redirect target is forced even
    cycle(0, 1, 16'h0021, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 16'h0100, 0, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 5) == 0, ($urandom % 16) == 0, 16'($urandom),
            ($urandom % 30) == 0, ($urandom % 4) != 0);
    end

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req", {15'd0, imem_req}, 16'd1);
    repeat (4) cycle(0, 0, 0, 0, 1);

    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit five-stage pipeline. It sits directly upstream of `decode_stage`:
- holds the PC and drives the instruction-memory read port;
- absorbs memory wait states;
- owns the IF/ID pipeline register, whose `instruction` and `pc_plus2` feed decode;
- honours stall, branch-redirect flush and halt.

## Interface
Parameters:
- `RESET_PC`, default `16'h0000`: PC loaded on reset.
- `NOP_INSTR`, default `16'h0000`: value placed in IF/ID on a bubble.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `stall`  in  1: decode cannot accept; hold PC and IF/ID.
- `flush`  in  1: taken branch/jump resolved downstream; redirect fetch.
- `redirect_pc`  in  16: new PC, sampled when `flush`=1.
- `halt_req`  in  1: decode has an accepted HLT in flight; stop fetching.
- `imem_addr`  out  16: current PC, byte address.
- `imem_req`  out  1: read request.
- `imem_data`  in  16: instruction word at `imem_addr`.
- `imem_valid`  in  1: `imem_data` is valid this cycle.
- `instruction`  out  16: IF/ID instruction.
- `pc_plus2`  out  16: IF/ID PC+2, used by decode for `alu_src1`/branches.
- `if_valid`  out  1: IF/ID holds a real instruction (0 = bubble).
- `halted`  out  1: fetch stopped in HALTED state.

## Operation
- The FSM has two states, FETCH and HALTED; reset enters FETCH.
- `imem_addr` = PC register (combinational); `imem_req` = (state==FETCH).
- Priority each edge: `rst` > `flush` > `stall` > normal.
- **flush:**
  - PC <= `redirect_pc`; `if_valid` <= 0; `instruction` <= `NOP_INSTR`; state <= FETCH (also leaves HALTED).
  - Any word returned that cycle is discarded.
- **stall (no flush):** PC, `instruction`, `pc_plus2`, `if_valid` and state all hold; `imem_data` is ignored, and the same address is refetched after the stall.
- **Normal, FETCH, `imem_valid`=1:**
  - `instruction` <= `imem_data`; `pc_plus2` <= PC+2; `if_valid` <= 1; PC <= PC+2.
- **Normal, FETCH, `imem_valid`=0:** PC holds; `if_valid` <= 0; `instruction` <= `NOP_INSTR` (bubble).
- **`halt_req`=1 (no flush, no stall):**
  - state <= HALTED; PC holds.
  - The word fetched this cycle is discarded; IF/ID <= bubble.
- **HALTED:** `imem_req`=0; IF/ID <= bubble unless stalled; `halted`=1. Only `flush` or `rst` exits.
- Arithmetic: PC+2 is modulo 2^16, so `16'hFFFE` wraps to `16'h0000`. `redirect_pc[0]` is forced to 0.

## Timing
- Reset values:
  - PC=`RESET_PC`, `instruction`=`NOP_INSTR`, `pc_plus2`=`16'h0000`, `if_valid`=0, `halted`=0.
  - `imem_req`=0 while `rst`=1, then 1 in the first cycle after deassertion.
- Reset asserted mid-operation clears all state immediately (asynchronous), without waiting for an edge.
- Latency: a word accepted with `imem_valid` at edge N appears on `instruction` after edge N.
- Zero-wait memory gives one instruction per cycle.
- Redirect penalty: one bubble. The flush edge loads `redirect_pc`; the target instruction is in IF/ID one edge later if `imem_valid`.
- `flush` and `stall` in the same cycle: flush wins.
- `halt_req` and `stall` in the same cycle: stall wins, and `halt_req` is re-evaluated the next cycle.
- `imem_addr` is stable whenever `imem_req`=1 and `imem_valid`=0.

## Configuration
- Macro `FETCH_HALT_DETECT_EN`.
- **Defined:** fetch predecodes the opcode. In FETCH with `imem_valid`=1, no flush, no stall and `imem_data[15:12]`=`4'hF`:
  - the HLT is latched into IF/ID with `if_valid`=1;
  - PC holds at the HLT address (no +2);
  - state <= HALTED on that same edge.
  - `halt_req` is still honoured.
- **Undefined:** no predecode; HALTED is entered only through `halt_req`.

## Test plan
- **Reset, straight-line fetch:** `RESET_PC`=0, memory 0-wait → after reset, `imem_addr` steps 0,2,4,…; `instruction`/`pc_plus2` lag by one cycle; `if_valid`=1 every cycle.
- **Wait states:** `imem_valid` low for 2 cycles at PC=`16'h0006` → `imem_addr` holds at 6; two bubbles (`if_valid`=0, `instruction`=`NOP_INSTR`); then the word at 6 with `pc_plus2`=`16'h0008`.
- **Stall vs flush:**
  - `stall` for 3 cycles → IF/ID and PC frozen.
  - `stall`+`flush` with `redirect_pc`=`16'h0040` → flush wins; next `imem_addr`=`16'h0040`; one bubble; then the target word.
- **Wrap:** PC=`16'hFFFE` fetched → `pc_plus2`=`16'h0000`; next `imem_addr`=`16'h0000`.
- **Halt:**
  - Macro off: `halt_req` pulse → `halted`=1, `imem_req`=0, IF/ID bubble; a later `flush` to `16'h0010` resumes fetch.
  - Macro on: word `16'hF000` at `16'h0020` → `if_valid`=1 with the HLT; `imem_addr` stays `16'h0020`; `halted`=1 next cycle.
- **Async reset mid-stream:** assert `rst` between edges → all outputs reach reset values before the next edge.
